// File: rtl/core_debug_pkg.sv
// rtl/core_debug_pkg.sv - command, target and state definitions shared by the debug responder and the debugger
package core_debug_pkg;

    typedef enum logic [3:0] {
        CMD_READ_REG   = 4'h0,
        CMD_WRITE_REG  = 4'h1,
        CMD_GO         = 4'h8,
        CMD_INTGO      = 4'h9,
        CMD_SINGLESTEP = 4'hA,
        CMD_STOP       = 4'hF
    } core_debug_cmd_e;

    // Targets 0-31 are the general registers GR0..GR31
    localparam logic [11:0] TGT_GR0   = 12'd0;
    localparam logic [11:0] TGT_GR31  = 12'd31;
    localparam logic [11:0] TGT_FLAGR = 12'd32;
    localparam logic [11:0] TGT_SPR   = 12'd33;
    localparam logic [11:0] TGT_PCR   = 12'd34;
    localparam logic [11:0] TGT_PPCR  = 12'd35;
    localparam logic [11:0] TGT_PSR   = 12'd36;
    localparam logic [11:0] TGT_PPSR  = 12'd37;
    localparam logic [11:0] CORE_DEBUG_TARGET_MAX = 12'd37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STOP_WAIT,
        ST_STEP_WAIT,
        ST_REG_WAIT,
        ST_RESP
    } core_debug_state_e;

    function automatic logic core_debug_target_ok(input logic [11:0] target);
        return target <= CORE_DEBUG_TARGET_MAX;
    endfunction

endpackage

// File: rtl/core_debug_timeout.sv
// rtl/core_debug_timeout.sv - loadable 16-bit down-counter bounding core-side acknowledge waits
module core_debug_timeout (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iCLEAR,
    input  logic        iENABLE,
    input  logic [15:0] iLOAD_VALUE,
    output logic        oTERMINAL
);

    logic [15:0] count;

    // Saturates at zero so the terminal flag stays up until the next clear
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            count <= 16'd0;
        end else if (iCLEAR) begin
            count <= iLOAD_VALUE;
        end else if (iENABLE && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign oTERMINAL = (count == 16'd0);

endmodule

// File: rtl/core_debug_responder.sv
// rtl/core_debug_responder.sv - core-side debug command endpoint: halt/step/interrupt control and register access
module core_debug_responder
    import core_debug_pkg::*;
#(
    parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iDEBUG_CMD_REQ,
    output logic        oDEBUG_CMD_BUSY,
    input  logic [3:0]  iDEBUG_CMD_COMMAND,
    input  logic [11:0] iDEBUG_CMD_TARGET,
    input  logic [31:0] iDEBUG_CMD_DATA,
    output logic        oDEBUG_CMD_VALID,
    output logic        oDEBUG_CMD_ERROR,
    output logic [31:0] oDEBUG_CMD_DATA,
    output logic        oCORE_HALT_REQ,
    input  logic        iCORE_HALTED,
    output logic        oCORE_STEP,
    input  logic        iCORE_STEP_DONE,
    output logic        oCORE_INT_REQ,
    output logic        oREG_REQ,
    output logic        oREG_WRITE,
    output logic [5:0]  oREG_ADDR,
    output logic [31:0] oREG_WDATA,
    input  logic        iREG_ACK,
    input  logic [31:0] iREG_RDATA
);

    localparam logic [15:0] TMO_LOAD = (P_TIMEOUT == 16'd0) ? 16'd0 : P_TIMEOUT - 16'd1;

    core_debug_state_e state;
    logic              b_halted;
    logic              tmo_clear;
    logic              tmo_enable;
    logic              tmo_terminal;

    // Loading on acceptance means the count is fresh on the first wait cycle
    assign tmo_clear  = (state == ST_IDLE) && iDEBUG_CMD_REQ;
    assign tmo_enable = (state == ST_STOP_WAIT) || (state == ST_STEP_WAIT) || (state == ST_REG_WAIT);

    core_debug_timeout u_timeout (
        .iCLOCK      (iCLOCK),
        .iRESET      (iRESET),
        .iCLEAR      (tmo_clear),
        .iENABLE     (tmo_enable),
        .iLOAD_VALUE (TMO_LOAD),
        .oTERMINAL   (tmo_terminal)
    );

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state            <= ST_IDLE;
            b_halted         <= 1'b0;
            oDEBUG_CMD_BUSY  <= 1'b0;
            oDEBUG_CMD_VALID <= 1'b0;
            oDEBUG_CMD_ERROR <= 1'b0;
            oDEBUG_CMD_DATA  <= 32'd0;
            oCORE_HALT_REQ   <= 1'b0;
            oCORE_STEP       <= 1'b0;
            oCORE_INT_REQ    <= 1'b0;
            oREG_REQ         <= 1'b0;
            oREG_WRITE       <= 1'b0;
            oREG_ADDR        <= 6'd0;
            oREG_WDATA       <= 32'd0;
        end else begin
            oDEBUG_CMD_VALID <= 1'b0;
            oDEBUG_CMD_ERROR <= 1'b0;
            oCORE_STEP       <= 1'b0;
            oCORE_INT_REQ    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iDEBUG_CMD_REQ) begin
                        oDEBUG_CMD_BUSY <= 1'b1;
                        case (iDEBUG_CMD_COMMAND)
                            CMD_STOP: begin
                                if (b_halted) begin
                                    oDEBUG_CMD_VALID <= 1'b1;
                                    oDEBUG_CMD_DATA  <= 32'd0;
                                    state            <= ST_RESP;
                                end else begin
                                    oCORE_HALT_REQ <= 1'b1;
                                    state          <= ST_STOP_WAIT;
                                end
                            end
                            CMD_GO, CMD_INTGO: begin
                                b_halted         <= 1'b0;
                                oCORE_HALT_REQ   <= 1'b0;
                                oCORE_INT_REQ    <= b_halted && (iDEBUG_CMD_COMMAND == CMD_INTGO);
                                oDEBUG_CMD_VALID <= 1'b1;
                                oDEBUG_CMD_DATA  <= 32'd0;
                                state            <= ST_RESP;
                            end
                            CMD_SINGLESTEP: begin
                                if (b_halted) begin
                                    oCORE_STEP <= 1'b1;
                                    state      <= ST_STEP_WAIT;
                                end else begin
                                    oDEBUG_CMD_VALID <= 1'b1;
                                    oDEBUG_CMD_ERROR <= 1'b1;
                                    oDEBUG_CMD_DATA  <= 32'd0;
                                    state            <= ST_RESP;
                                end
                            end
                            CMD_READ_REG, CMD_WRITE_REG: begin
                                if (b_halted && core_debug_target_ok(iDEBUG_CMD_TARGET)) begin
                                    oREG_REQ   <= 1'b1;
                                    oREG_WRITE <= (iDEBUG_CMD_COMMAND == CMD_WRITE_REG);
                                    oREG_ADDR  <= iDEBUG_CMD_TARGET[5:0];
                                    oREG_WDATA <= iDEBUG_CMD_DATA;
                                    state      <= ST_REG_WAIT;
                                end else begin
                                    oDEBUG_CMD_VALID <= 1'b1;
                                    oDEBUG_CMD_ERROR <= 1'b1;
                                    oDEBUG_CMD_DATA  <= 32'd0;
                                    state            <= ST_RESP;
                                end
                            end
                            default: begin
                                oDEBUG_CMD_VALID <= 1'b1;
                                oDEBUG_CMD_ERROR <= 1'b1;
                                oDEBUG_CMD_DATA  <= 32'd0;
                                state            <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_STOP_WAIT: begin
                    // A failed stop releases the core so it is not left half-stopped
                    if (iCORE_HALTED || tmo_terminal) begin
                        b_halted         <= iCORE_HALTED;
                        oCORE_HALT_REQ   <= iCORE_HALTED;
                        oDEBUG_CMD_VALID <= 1'b1;
                        oDEBUG_CMD_ERROR <= !iCORE_HALTED;
                        oDEBUG_CMD_DATA  <= 32'd0;
                        state            <= ST_RESP;
                    end
                end
                ST_STEP_WAIT: begin
                    if (iCORE_STEP_DONE || tmo_terminal) begin
                        oDEBUG_CMD_VALID <= 1'b1;
                        oDEBUG_CMD_ERROR <= !iCORE_STEP_DONE;
                        oDEBUG_CMD_DATA  <= 32'd0;
                        state            <= ST_RESP;
                    end
                end
                ST_REG_WAIT: begin
                    if (iREG_ACK || tmo_terminal) begin
                        oREG_REQ         <= 1'b0;
                        oDEBUG_CMD_VALID <= 1'b1;
                        oDEBUG_CMD_ERROR <= !iREG_ACK;
                        oDEBUG_CMD_DATA  <= (iREG_ACK && !oREG_WRITE) ? iREG_RDATA : 32'd0;
                        state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    oDEBUG_CMD_BUSY <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    oDEBUG_CMD_BUSY <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_debug_responder.sv
// tb/tb_core_debug_responder.sv - randomized self-checking bench for core_debug_responder
module tb_core_debug_responder;

    localparam int P = 8;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iDEBUG_CMD_REQ;
    logic        oDEBUG_CMD_BUSY;
    logic [3:0]  iDEBUG_CMD_COMMAND;
    logic [11:0] iDEBUG_CMD_TARGET;
    logic [31:0] iDEBUG_CMD_DATA;
    logic        oDEBUG_CMD_VALID;
    logic        oDEBUG_CMD_ERROR;
    logic [31:0] oDEBUG_CMD_DATA;
    logic        oCORE_HALT_REQ;
    logic        iCORE_HALTED;
    logic        oCORE_STEP;
    logic        iCORE_STEP_DONE;
    logic        oCORE_INT_REQ;
    logic        oREG_REQ;
    logic        oREG_WRITE;
    logic [5:0]  oREG_ADDR;
    logic [31:0] oREG_WDATA;
    logic        iREG_ACK;
    logic [31:0] iREG_RDATA;

    always #5 iCLOCK = ~iCLOCK;

    core_debug_responder #(.P_TIMEOUT(16'd8)) dut (
        .iCLOCK             (iCLOCK),
        .iRESET             (iRESET),
        .iDEBUG_CMD_REQ     (iDEBUG_CMD_REQ),
        .oDEBUG_CMD_BUSY    (oDEBUG_CMD_BUSY),
        .iDEBUG_CMD_COMMAND (iDEBUG_CMD_COMMAND),
        .iDEBUG_CMD_TARGET  (iDEBUG_CMD_TARGET),
        .iDEBUG_CMD_DATA    (iDEBUG_CMD_DATA),
        .oDEBUG_CMD_VALID   (oDEBUG_CMD_VALID),
        .oDEBUG_CMD_ERROR   (oDEBUG_CMD_ERROR),
        .oDEBUG_CMD_DATA    (oDEBUG_CMD_DATA),
        .oCORE_HALT_REQ     (oCORE_HALT_REQ),
        .iCORE_HALTED       (iCORE_HALTED),
        .oCORE_STEP         (oCORE_STEP),
        .iCORE_STEP_DONE    (iCORE_STEP_DONE),
        .oCORE_INT_REQ      (oCORE_INT_REQ),
        .oREG_REQ           (oREG_REQ),
        .oREG_WRITE         (oREG_WRITE),
        .oREG_ADDR          (oREG_ADDR),
        .oREG_WDATA         (oREG_WDATA),
        .iREG_ACK           (iREG_ACK),
        .iREG_RDATA         (iREG_RDATA)
    );

    int total = 0;
    int bad   = 0;
    bit m_halted = 1'b0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] data;
        logic        busy_valid;
        int          nvalid;
        logic        busy_after;
        logic        halt_c1;
        logic        halt_after;
        logic        regreq_seen;
        logic        regreq_after;
        logic [5:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        int          nstep;
        int          nint;
    } obs_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] data;
        logic        regreq;
        int          nstep;
        int          nint;
        logic        halted;
    } exp_t;

    function automatic logic [64:0] all_outputs();
        return {oDEBUG_CMD_BUSY, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR, oDEBUG_CMD_DATA[0],
                oCORE_HALT_REQ, oCORE_STEP, oCORE_INT_REQ, oREG_REQ, oREG_WRITE,
                |oDEBUG_CMD_DATA, oREG_ADDR, oREG_WDATA, 19'd0};
    endfunction

    // Reference: outcome of one command from the current halted state and the ack cycle d (0 = never)
    task automatic model(input logic [3:0] cmd, input logic [11:0] tgt, input int d,
                         input logic [31:0] rd, output exp_t e);
        bit wait_ok;
        int wait_lat;
        wait_ok  = (d >= 1) && (d <= P);
        wait_lat = wait_ok ? d + 1 : P + 1;
        e.lat = 1; e.err = 1'b0; e.data = 32'd0; e.regreq = 1'b0; e.nstep = 0; e.nint = 0;
        case (cmd)
            4'hF: if (!m_halted) begin
                e.lat = wait_lat; e.err = !wait_ok; m_halted = wait_ok;
            end
            4'h8: m_halted = 1'b0;
            4'h9: begin e.nint = m_halted ? 1 : 0; m_halted = 1'b0; end
            4'hA: if (!m_halted) e.err = 1'b1;
                  else begin e.nstep = 1; e.lat = wait_lat; e.err = !wait_ok; end
            4'h0, 4'h1: if (!m_halted || tgt > 12'd37) e.err = 1'b1;
                  else begin
                      e.regreq = 1'b1; e.lat = wait_lat; e.err = !wait_ok;
                      if (cmd == 4'h0 && wait_ok) e.data = rd;
                  end
            default: e.err = 1'b1;
        endcase
        e.halted = m_halted;
    endtask

    // Issues one command, plays the core side and records what the responder did
    task automatic run_cmd(input logic [3:0] cmd, input logic [11:0] tgt, input logic [31:0] wd,
                           input int d, input logic [31:0] rd, output obs_t o);
        o.lat = -1; o.err = 1'bx; o.data = 'x; o.busy_valid = 1'bx; o.nvalid = 0;
        o.busy_after = 1'bx; o.halt_c1 = 1'bx; o.halt_after = 1'bx; o.regreq_seen = 1'b0;
        o.regreq_after = 1'bx; o.addr = 'x; o.wr = 1'bx; o.wdata = 'x; o.nstep = 0; o.nint = 0;
        @(negedge iCLOCK);
        iDEBUG_CMD_REQ = 1'b1; iDEBUG_CMD_COMMAND = cmd; iDEBUG_CMD_TARGET = tgt; iDEBUG_CMD_DATA = wd;
        for (int k = 1; k <= 40; k++) begin
            @(negedge iCLOCK);
            if (k == 1) begin iDEBUG_CMD_REQ = 1'b0; o.halt_c1 = oCORE_HALT_REQ; end
            if (oCORE_STEP) o.nstep++;
            if (oCORE_INT_REQ) o.nint++;
            if (o.lat < 0) begin
                if (oREG_REQ && !o.regreq_seen) begin
                    o.regreq_seen = 1'b1; o.addr = oREG_ADDR; o.wr = oREG_WRITE; o.wdata = oREG_WDATA;
                end
                if (oDEBUG_CMD_VALID) begin
                    o.lat = k; o.err = oDEBUG_CMD_ERROR; o.data = oDEBUG_CMD_DATA;
                    o.busy_valid = oDEBUG_CMD_BUSY; o.nvalid++;
                    iCORE_HALTED = 1'b0; iCORE_STEP_DONE = 1'b0; iREG_ACK = 1'b0;
                end else begin
                    iCORE_HALTED    = (cmd == 4'hF) && (d > 0) && (k >= d);
                    iCORE_STEP_DONE = (cmd == 4'hA) && (k == d);
                    iREG_ACK        = (cmd <= 4'h1) && (k == d);
                    iREG_RDATA      = iREG_ACK ? rd : $urandom;
                end
            end else begin
                if (oDEBUG_CMD_VALID) o.nvalid++;
                o.busy_after = oDEBUG_CMD_BUSY; o.halt_after = oCORE_HALT_REQ; o.regreq_after = oREG_REQ;
                break;
            end
        end
        iCORE_HALTED = 1'b0; iCORE_STEP_DONE = 1'b0; iREG_ACK = 1'b0;
    endtask

    task automatic do_cmd(input logic [3:0] cmd, input logic [11:0] tgt, input int d,
                          output obs_t o, output exp_t e);
        logic [31:0] wd, rd;
        wd = $urandom; rd = $urandom;
        model(cmd, tgt, d, rd, e);
        run_cmd(cmd, tgt, wd, d, rd, o);
        if (o.regreq_seen === 1'b1 && cmd == 4'h1 && o.wdata !== wd) begin
            total++; bad++;
            $display("FAIL wdata: got %h want %h", o.wdata, wd);
        end
    endtask

    task automatic test_reset();
        iRESET = 1'b1; iDEBUG_CMD_REQ = 1'b0; iDEBUG_CMD_COMMAND = 4'h0; iDEBUG_CMD_TARGET = 12'd0;
        iDEBUG_CMD_DATA = 32'd0; iCORE_HALTED = 1'b0; iCORE_STEP_DONE = 1'b0; iREG_ACK = 1'b0;
        iREG_RDATA = 32'd0;
        repeat (3) @(negedge iCLOCK);
        total++;
        if (all_outputs() !== 65'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
        iRESET = 1'b0; m_halted = 1'b0;
        @(negedge iCLOCK);
        total++;
        if (all_outputs() !== 65'd0) begin bad++; $display("FAIL idle_outputs: got %h want 0", all_outputs()); end
    endtask

    task automatic test_stop();
        obs_t o; exp_t e;
        do_cmd(4'hF, 12'd0, 3, o, e);
        total++; if (o.lat !== 4 || o.err !== 1'b0) begin bad++; $display("FAIL stop_wait: lat %0d err %b want 4 0", o.lat, o.err); end
        total++; if (o.halt_c1 !== 1'b1 || o.halt_after !== 1'b1) begin bad++; $display("FAIL stop_halt_req: c1 %b after %b want 1 1", o.halt_c1, o.halt_after); end
        total++; if (o.busy_valid !== 1'b1 || o.busy_after !== 1'b0) begin bad++; $display("FAIL stop_busy: valid-cycle %b after %b want 1 0", o.busy_valid, o.busy_after); end
        do_cmd(4'hF, 12'd0, 0, o, e);
        total++; if (o.lat !== 1 || o.err !== 1'b0 || o.nvalid !== 1) begin bad++; $display("FAIL stop_repeat: lat %0d err %b n %0d want 1 0 1", o.lat, o.err, o.nvalid); end
    endtask

    task automatic test_reg_read();
        obs_t o; exp_t e;
        model(4'h0, 12'd34, 2, 32'hDEADBEEF, e);
        run_cmd(4'h0, 12'd34, 32'd0, 2, 32'hDEADBEEF, o);
        total++; if (o.regreq_seen !== 1'b1 || o.addr !== 6'd34 || o.wr !== 1'b0) begin bad++; $display("FAIL read_req: seen %b addr %0d wr %b want 1 34 0", o.regreq_seen, o.addr, o.wr); end
        total++; if (o.lat !== 3 || o.err !== 1'b0 || o.data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_resp: lat %0d err %b data %h want 3 0 deadbeef", o.lat, o.err, o.data); end
        total++; if (o.regreq_after !== 1'b0) begin bad++; $display("FAIL read_req_drop: got %b want 0", o.regreq_after); end
    endtask

    task automatic test_reg_errors();
        obs_t o; exp_t e;
        do_cmd(4'h8, 12'd0, 0, o, e);
        do_cmd(4'h1, 12'd5, 1, o, e);
        total++; if (o.lat !== 1 || o.err !== 1'b1 || o.regreq_seen !== 1'b0) begin bad++; $display("FAIL write_running: lat %0d err %b req %b want 1 1 0", o.lat, o.err, o.regreq_seen); end
        do_cmd(4'hF, 12'd0, 1, o, e);
        do_cmd(4'h1, 12'd38, 1, o, e);
        total++; if (o.lat !== 1 || o.err !== 1'b1 || o.regreq_seen !== 1'b0) begin bad++; $display("FAIL write_tgt38: lat %0d err %b req %b want 1 1 0", o.lat, o.err, o.regreq_seen); end
        do_cmd(4'h1, 12'd37, 1, o, e);
        total++; if (o.lat !== 2 || o.err !== 1'b0 || o.wr !== 1'b1 || o.addr !== 6'd37 || o.data !== 32'd0) begin bad++; $display("FAIL write_tgt37: lat %0d err %b wr %b addr %0d data %h want 2 0 1 37 0", o.lat, o.err, o.wr, o.addr, o.data); end
    endtask

    task automatic test_step_intgo();
        obs_t o; exp_t e;
        do_cmd(4'hA, 12'd0, 4, o, e);
        total++; if (o.nstep !== 1 || o.lat !== 5 || o.err !== 1'b0 || o.halt_after !== 1'b1) begin bad++; $display("FAIL step: pulses %0d lat %0d err %b halt %b want 1 5 0 1", o.nstep, o.lat, o.err, o.halt_after); end
        do_cmd(4'h9, 12'd0, 0, o, e);
        total++; if (o.nint !== 1 || o.lat !== 1 || o.err !== 1'b0 || o.halt_after !== 1'b0) begin bad++; $display("FAIL intgo: int %0d lat %0d err %b halt %b want 1 1 0 0", o.nint, o.lat, o.err, o.halt_after); end
        do_cmd(4'h9, 12'd0, 0, o, e);
        total++; if (o.nint !== 0 || o.err !== 1'b0) begin bad++; $display("FAIL intgo_running: int %0d err %b want 0 0", o.nint, o.err); end
        do_cmd(4'hA, 12'd0, 1, o, e);
        total++; if (o.nstep !== 0 || o.lat !== 1 || o.err !== 1'b1) begin bad++; $display("FAIL step_running: pulses %0d lat %0d err %b want 0 1 1", o.nstep, o.lat, o.err); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        do_cmd(4'hF, 12'd0, 0, o, e);
        total++; if (o.lat !== P + 1 || o.err !== 1'b1 || o.halt_c1 !== 1'b1 || o.halt_after !== 1'b0) begin bad++; $display("FAIL stop_timeout: lat %0d err %b c1 %b after %b want %0d 1 1 0", o.lat, o.err, o.halt_c1, o.halt_after, P + 1); end
        do_cmd(4'hF, 12'd0, P, o, e);
        total++; if (o.lat !== P + 1 || o.err !== 1'b0 || o.halt_after !== 1'b1) begin bad++; $display("FAIL stop_ack_at_limit: lat %0d err %b halt %b want %0d 0 1", o.lat, o.err, o.halt_after, P + 1); end
        do_cmd(4'h0, 12'd7, 0, o, e);
        total++; if (o.lat !== P + 1 || o.err !== 1'b1 || o.data !== 32'd0 || o.regreq_after !== 1'b0) begin bad++; $display("FAIL read_timeout: lat %0d err %b data %h req %b want %0d 1 0 0", o.lat, o.err, o.data, o.regreq_after, P + 1); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v, b;
        @(negedge iCLOCK);
        iDEBUG_CMD_REQ = 1'b1; iDEBUG_CMD_COMMAND = 4'h8;
        for (int k = 1; k <= 4; k++) begin
            @(negedge iCLOCK);
            v[4-k] = oDEBUG_CMD_VALID; b[4-k] = oDEBUG_CMD_BUSY;
            if (k == 3) iDEBUG_CMD_REQ = 1'b0;
        end
        m_halted = 1'b0;
        total++; if (v !== 4'b1010 || b !== 4'b1010) begin bad++; $display("FAIL back_to_back: valid %b busy %b want 1010 1010", v, b); end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        int nv;
        do_cmd(4'hF, 12'd0, 1, o, e);
        @(negedge iCLOCK);
        iDEBUG_CMD_REQ = 1'b1; iDEBUG_CMD_COMMAND = 4'h0; iDEBUG_CMD_TARGET = 12'd3;
        @(negedge iCLOCK);
        iDEBUG_CMD_REQ = 1'b0;
        total++; if (oREG_REQ !== 1'b1) begin bad++; $display("FAIL mid_reg_req: got %b want 1", oREG_REQ); end
        repeat (2) @(negedge iCLOCK);
        #2 iRESET = 1'b1;
        #1;
        total++; if (all_outputs() !== 65'd0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", all_outputs()); end
        @(negedge iCLOCK);
        iRESET = 1'b0; m_halted = 1'b0;
        nv = 0;
        repeat (3) begin @(negedge iCLOCK); if (oDEBUG_CMD_VALID !== 1'b0) nv++; end
        total++; if (nv !== 0) begin bad++; $display("FAIL mid_reset_valid: got %0d pulses want 0", nv); end
        do_cmd(4'h8, 12'd0, 0, o, e);
        total++; if (o.lat !== 1 || o.err !== 1'b0) begin bad++; $display("FAIL go_after_reset: lat %0d err %b want 1 0", o.lat, o.err); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [3:0] codes [8];
        logic [3:0] cmd;
        logic [11:0] tgt;
        codes = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hF, 4'h2, 4'h7};
        for (int i = 0; i < 60; i++) begin
            cmd = codes[$urandom_range(0, 7)];
            tgt = 12'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) tgt = 12'($urandom_range(0, 4095));
            do_cmd(cmd, tgt, $urandom_range(0, 10), o, e);
            total++;
            if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data) begin
                bad++; $display("FAIL rand_resp[%0d] cmd %h tgt %0d: lat %0d err %b data %h want %0d %b %h",
                                i, cmd, tgt, o.lat, o.err, o.data, e.lat, e.err, e.data);
            end
            total++;
            if (o.nvalid !== 1 || o.busy_valid !== 1'b1 || o.busy_after !== 1'b0) begin
                bad++; $display("FAIL rand_handshake[%0d]: nvalid %0d busy %b/%b want 1 1/0", i, o.nvalid, o.busy_valid, o.busy_after);
            end
            total++;
            if (o.regreq_seen !== e.regreq || o.regreq_after !== 1'b0 || o.nstep !== e.nstep ||
                o.nint !== e.nint || o.halt_after !== e.halted) begin
                bad++; $display("FAIL rand_core[%0d]: req %b/%b step %0d int %0d halt %b want %b/0 %0d %0d %b",
                                i, o.regreq_seen, o.regreq_after, o.nstep, o.nint, o.halt_after,
                                e.regreq, e.nstep, e.nint, e.halted);
            end
            if (e.regreq) begin
                total++;
                if (o.addr !== tgt[5:0] || o.wr !== (cmd == 4'h1)) begin
                    bad++; $display("FAIL rand_reg_addr[%0d]: addr %0d wr %b want %0d %b", i, o.addr, o.wr, tgt[5:0], cmd == 4'h1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stop();
        test_reg_read();
        test_reg_errors();
        test_step_intgo();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
